// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 vectors of a 4-input combinational function f onto
// {a,b,c,d}. It holds each vector for SETTLE cycles and then samples f's output s_in into
// a 16-bit truth table. When the sweep ends it reports the table, its popcount, and whether
// the table equals EXPECTED.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   start      - level, sampled only in IDLE or DONE
//   s_in       - output s of f, fed back from the function under test
//   a,b,c,d    - current vector, a is the MSB
//   busy       - high while driving or sampling
//   done       - high once a sweep has finished
//   table_out  - captured table; bit m holds s for vector m
//   ones_count - number of ones captured (0..16)
//   match      - high in DONE when table_out == EXPECTED
//
// Optional build macro SWEEP_GRAY_EN: when it is defined, vectors are driven in Gray order.
// Bit placement in table_out is unchanged, so results are order-independent.

module truth_table_sweeper #(
  parameter logic [15:0] EXPECTED = 16'hAC3C,
  parameter int unsigned SETTLE   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        s_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  ones_count,
  output logic        match
);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  // Maps the sweep index to the vector actually driven.
  function automatic logic [3:0] vec_of(input logic [3:0] i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  vec_q, vec_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        match_q, match_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  ones_q, ones_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    match_d = match_q;
    table_d = table_q;
    ones_d  = ones_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StDrive;
          idx_d   = 4'd0;
          cnt_d   = 4'd0;
          vec_d   = vec_of(4'd0);
          busy_d  = 1'b1;
          done_d  = 1'b0;
          match_d = 1'b0;
          table_d = 16'h0000;
          ones_d  = 5'd0;
        end
      end
      StDrive: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = 4'd0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        table_d[vec_of(idx_q)] = s_in;
        ones_d = ones_q + {4'd0, s_in};
        if (idx_q == 4'd15) begin
          state_d = StDone;
          vec_d   = 4'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Compare against the table including this final sample.
          match_d = (table_d == EXPECTED);
        end else begin
          idx_d   = idx_q + 4'd1;
          vec_d   = vec_of(idx_q + 4'd1);
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      vec_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      table_q <= 16'h0000;
      ones_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
      table_q <= table_d;
      ones_q  <= ones_d;
    end
  end

  assign {a, b, c, d} = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign match        = match_q;
  assign table_out    = table_q;
  assign ones_count   = ones_q;

endmodule
